// File: rtl/y86_defs.sv
// Shared Y86-64 definitions for the decode slice.
//   - Instruction codes IHALT..IPOPQ
//   - Register identifiers: RNONE (no register) and RRSP (stack pointer)
//   - DATA_W: datapath width; NREG: number of architectural registers
//   - e_reg_t: packed layout of the E pipeline register
//   - E_BUBBLE: the nop image loaded into E on reset or bubble
package y86_defs;

  localparam int DATA_W = 64;
  localparam int NREG   = 15;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  typedef struct packed {
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [DATA_W-1:0] val_c;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
    logic [3:0]        src_a;
    logic [3:0]        src_b;
  } e_reg_t;

  localparam e_reg_t E_BUBBLE = '{
    icode: INOP,
    ifun:  4'h0,
    val_c: '0,
    val_a: '0,
    val_b: '0,
    dst_e: RNONE,
    dst_m: RNONE,
    src_a: RNONE,
    src_b: RNONE
  };

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: 15 x DATA_W registers.
// Ports:
//   clock, reset       posedge clock, synchronous active-high reset (clears all registers)
//   src_a, src_b       read addresses; RNONE reads as 0
//   val_a, val_b       combinational read data (pre-write contents)
//   dst_e, val_e       write port E (ignored when dst_e is RNONE)
//   dst_m, val_m       write port M (ignored when dst_m is RNONE); wins over E on same index
module y86_regfile
  import y86_defs::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        src_a,
  input  logic [3:0]        src_b,
  output logic [DATA_W-1:0] val_a,
  output logic [DATA_W-1:0] val_b,
  input  logic [3:0]        dst_e,
  input  logic [DATA_W-1:0] val_e,
  input  logic [3:0]        dst_m,
  input  logic [DATA_W-1:0] val_m
);

  logic [DATA_W-1:0] regs [NREG];

  // Reset clears every register and drops any write in that cycle. The M
  // write is scheduled after the E write so that popq %rsp ends up with the
  // value loaded from memory rather than the incremented stack pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (dst_e != RNONE) begin
        regs[dst_e] <= val_e;
      end
      if (dst_m != RNONE) begin
        regs[dst_m] <= val_m;
      end
    end
  end

  assign val_a = (src_a == RNONE) ? '0 : regs[src_a];
  assign val_b = (src_b == RNONE) ? '0 : regs[src_b];

endmodule

// File: rtl/decode_stage.sv
// Y86-64 pipeline decode stage.
// Derives srcA/srcB/dstE/dstM from the D-register fields, reads the register
// file, optionally forwards from E/M/W, and loads the E pipeline register
// under stall/bubble control. The register file is instantiated here and
// written from the W stage.
// Ports:
//   clock, reset                 posedge clock, synchronous active-high reset
//   d_icode..d_valP              D-register outputs
//   e_dstE/e_valE, m_dstE/m_valE, m_dstM/m_valM, w_dstE/w_valE, w_dstM/w_valM
//                                forwarding sources; W pair also writes the regfile
//   e_stall, e_bubble            E register hold / nop insertion (bubble wins)
//   d_srcA, d_srcB               combinational source ids for hazard control
//   E_*                          E pipeline register outputs
// Configuration macro: DECODE_FORWARD_EN
//   defined   -> valA/valB come from the E/M/W forwarding chain
//   undefined -> valA/valB come from valP or the register file only
module decode_stage
  import y86_defs::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        d_icode,
  input  logic [3:0]        d_ifun,
  input  logic [3:0]        d_regA,
  input  logic [3:0]        d_regB,
  input  logic [DATA_W-1:0] d_valC,
  input  logic [DATA_W-1:0] d_valP,
  input  logic [3:0]        e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [3:0]        m_dstE,
  input  logic [DATA_W-1:0] m_valE,
  input  logic [3:0]        m_dstM,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        w_dstE,
  input  logic [DATA_W-1:0] w_valE,
  input  logic [3:0]        w_dstM,
  input  logic [DATA_W-1:0] w_valM,
  input  logic              e_stall,
  input  logic              e_bubble,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [DATA_W-1:0] E_valC,
  output logic [DATA_W-1:0] E_valA,
  output logic [DATA_W-1:0] E_valB,
  output logic [3:0]        E_dstE,
  output logic [3:0]        E_dstM,
  output logic [3:0]        E_srcA,
  output logic [3:0]        E_srcB
);

  logic [3:0]        src_a;
  logic [3:0]        src_b;
  logic [3:0]        dst_e;
  logic [3:0]        dst_m;
  logic [DATA_W-1:0] rf_a;
  logic [DATA_W-1:0] rf_b;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [DATA_W-1:0] val_a;
  e_reg_t            e_next;
  e_reg_t            e_q;

  y86_regfile u_regfile (
    .clock (clock),
    .reset (reset),
    .src_a (src_a),
    .src_b (src_b),
    .val_a (rf_a),
    .val_b (rf_b),
    .dst_e (w_dstE),
    .val_e (w_valE),
    .dst_m (w_dstM),
    .val_m (w_valM)
  );

  // Register-id derivation. Unlisted and unknown icodes use no registers,
  // so they never create hazards or writes.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (d_icode)
      IRRMOVQ: begin
        src_a = d_regA;
        dst_e = d_regB;
      end
      IIRMOVQ: begin
        dst_e = d_regB;
      end
      IRMMOVQ: begin
        src_a = d_regA;
        src_b = d_regB;
      end
      IMRMOVQ: begin
        src_b = d_regB;
        dst_m = d_regA;
      end
      IOPQ: begin
        src_a = d_regA;
        src_b = d_regB;
        dst_e = d_regB;
      end
      ICALL: begin
        src_b = RRSP;
        dst_e = RRSP;
      end
      IRET: begin
        src_a = RRSP;
        src_b = RRSP;
        dst_e = RRSP;
      end
      IPUSHQ: begin
        src_a = d_regA;
        src_b = RRSP;
        dst_e = RRSP;
      end
      IPOPQ: begin
        src_a = RRSP;
        src_b = RRSP;
        dst_e = RRSP;
        dst_m = d_regA;
      end
      default: begin
      end
    endcase
  end

  assign d_srcA = src_a;
  assign d_srcB = src_b;

`ifdef DECODE_FORWARD_EN
  // Forwarding: the youngest producer wins. Within M the memory result is
  // preferred, and within W the M port is preferred, matching the regfile's
  // own write priority. RNONE sources never match.
  always_comb begin
    sel_a = rf_a;
    if (src_a != RNONE) begin
      if (src_a == e_dstE)      sel_a = e_valE;
      else if (src_a == m_dstM) sel_a = m_valM;
      else if (src_a == m_dstE) sel_a = m_valE;
      else if (src_a == w_dstM) sel_a = w_valM;
      else if (src_a == w_dstE) sel_a = w_valE;
    end
  end

  always_comb begin
    sel_b = rf_b;
    if (src_b != RNONE) begin
      if (src_b == e_dstE)      sel_b = e_valE;
      else if (src_b == m_dstM) sel_b = m_valM;
      else if (src_b == m_dstE) sel_b = m_valE;
      else if (src_b == w_dstM) sel_b = w_valM;
      else if (src_b == w_dstE) sel_b = w_valE;
    end
  end
`else
  // Without forwarding the hazard unit stalls until writeback is done, so
  // the pipeline-stage values are not consulted here.
  logic unused_fwd;
  assign unused_fwd = ^{e_dstE, e_valE, m_dstE, m_valE, m_dstM, m_valM};
  assign sel_a = rf_a;
  assign sel_b = rf_b;
`endif

  // call and jXX carry the return / fall-through address down in valA.
  assign val_a = (d_icode == ICALL || d_icode == IJXX) ? d_valP : sel_a;

  always_comb begin
    e_next       = E_BUBBLE;
    e_next.icode = d_icode;
    e_next.ifun  = d_ifun;
    e_next.val_c = d_valC;
    e_next.val_a = val_a;
    e_next.val_b = sel_b;
    e_next.dst_e = dst_e;
    e_next.dst_m = dst_m;
    e_next.src_a = src_a;
    e_next.src_b = src_b;
  end

  // E pipeline register: reset and bubble both inject a nop; bubble beats stall.
  always_ff @(posedge clock) begin
    if (reset || e_bubble) begin
      e_q <= E_BUBBLE;
    end else if (!e_stall) begin
      e_q <= e_next;
    end
  end

  assign E_icode = e_q.icode;
  assign E_ifun  = e_q.ifun;
  assign E_valC  = e_q.val_c;
  assign E_valA  = e_q.val_a;
  assign E_valB  = e_q.val_b;
  assign E_dstE  = e_q.dst_e;
  assign E_dstM  = e_q.dst_m;
  assign E_srcA  = e_q.src_a;
  assign E_srcB  = e_q.src_b;

endmodule
